// File: rtl/axi_master_mux_pkg.sv
// Shared cache-side AXI definitions: request/response bundles and the
// channel-tag ID pack/unpack helpers used by the master mux.
package axi_master_mux_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              valid;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
    logic                valid;
  } axi_w_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic              valid;
  } axi_r_t;

  typedef struct packed {
    logic [1:0] resp;
    logic       valid;
  } axi_b_t;

  typedef struct packed {
    axi_ax_t ar;
    axi_ax_t aw;
    axi_w_t  w;
    logic    rready;
    logic    bready;
  } axi_req_t;

  typedef struct packed {
    logic   arready;
    logic   awready;
    logic   wready;
    axi_r_t r;
    axi_b_t b;
  } axi_resp_t;

  function automatic int axi_id_tag_w(input int n_masters, input int bus_width);
    return $clog2(n_masters) + bus_width;
  endfunction

  // Downstream IDs carry the originating channel above the upstream ID bits.
  function automatic logic [31:0] mux_id_pack(input logic [31:0] ch, input logic [31:0] id,
                                              input int bus_width);
    return (ch << bus_width) | id;
  endfunction

  function automatic logic [31:0] mux_id_ch(input logic [31:0] tag, input int bus_width);
    return tag >> bus_width;
  endfunction

  function automatic logic [31:0] mux_id_low(input logic [31:0] tag, input int bus_width);
    return tag & ((32'd1 << bus_width) - 32'd1);
  endfunction

endpackage

// File: rtl/axi_master_mux_rr_arbiter.sv
// Round-robin arbiter whose grant is combinational while unlocked and frozen
// from the first stalled offer until the downstream handshake.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          lock,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          active
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] held_idx;
  logic          held;
  int            j;

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    grant  = '0;
    idx    = held_idx;
    active = held;
    j      = 0;
    if (!held) begin
      // Descending scan: the lowest offset from ptr overwrites last and wins.
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(ptr) + k;
        if (j >= N) j = j - N;
        if (req[j]) begin
          idx    = IW'(j);
          active = 1'b1;
        end
      end
    end
    if (active) grant[idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      held     <= 1'b0;
      held_idx <= '0;
    end else if (advance) begin
      held <= 1'b0;
      ptr  <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end else if (lock) begin
      held     <= 1'b1;
      held_idx <= idx;
    end
  end

endmodule

// File: rtl/axi_master_mux.sv
// Merges N_MASTERS cache-side AXI masters onto one tagged AXI port: RR AR/AW
// arbitration, W steered in AW-grant order, R/B routed by the ID channel tag.
module axi_master_mux
  import axi_master_mux_pkg::*;
#(
  parameter int N_MASTERS      = 3,
  parameter int BUS_WIDTH      = 4,
  parameter int CH_W           = $clog2(N_MASTERS),
  parameter int WR_OUTSTANDING = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  axi_req_t                  m_axi_req  [N_MASTERS],
  input  logic [BUS_WIDTH-1:0]      m_arid     [N_MASTERS],
  input  logic [BUS_WIDTH-1:0]      m_awid     [N_MASTERS],
  input  logic [BUS_WIDTH-1:0]      m_wid      [N_MASTERS],
  output axi_resp_t                 m_axi_resp [N_MASTERS],
  output logic [BUS_WIDTH-1:0]      m_rid      [N_MASTERS],
  output logic [BUS_WIDTH-1:0]      m_bid      [N_MASTERS],
  output axi_req_t                  s_axi_req,
  output logic [CH_W+BUS_WIDTH-1:0] s_arid,
  output logic [CH_W+BUS_WIDTH-1:0] s_awid,
  output logic [CH_W+BUS_WIDTH-1:0] s_wid,
  input  axi_resp_t                 s_axi_resp,
  input  logic [CH_W+BUS_WIDTH-1:0] s_rid,
  input  logic [CH_W+BUS_WIDTH-1:0] s_bid
);

  localparam int IDW = CH_W + BUS_WIDTH;
  localparam int PW  = $clog2(WR_OUTSTANDING);

  logic [N_MASTERS-1:0] ar_req, aw_req, ar_gnt, aw_gnt;
  logic [CH_W-1:0]      ar_idx, aw_idx, head, r_ch, b_ch;
  logic                 ar_any, aw_any, ar_valid, aw_valid, r_hit, b_hit;
  logic                 full, empty, push, pop;

  logic [CH_W-1:0]      fifo_mem [WR_OUTSTANDING];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW:0]          count;

  always_comb begin
    ar_req = '0;
    aw_req = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      ar_req[i] = m_axi_req[i].ar.valid & ~rst;
      aw_req[i] = m_axi_req[i].aw.valid & ~rst & ~full;
    end
  end

  rr_arbiter #(.N(N_MASTERS), .IW(CH_W)) u_ar_arb (
    .clk(clk), .rst(rst), .req(ar_req),
    .lock(ar_valid & ~s_axi_resp.arready), .advance(ar_valid & s_axi_resp.arready),
    .grant(ar_gnt), .idx(ar_idx), .active(ar_any)
  );

  rr_arbiter #(.N(N_MASTERS), .IW(CH_W)) u_aw_arb (
    .clk(clk), .rst(rst), .req(aw_req),
    .lock(aw_valid & ~s_axi_resp.awready), .advance(push),
    .grant(aw_gnt), .idx(aw_idx), .active(aw_any)
  );

  assign ar_valid = ar_any & m_axi_req[ar_idx].ar.valid & ~rst;
  assign aw_valid = aw_any & m_axi_req[aw_idx].aw.valid & ~full & ~rst;

  assign push  = aw_valid & s_axi_resp.awready;
  assign pop   = s_axi_req.w.valid & s_axi_resp.wready & s_axi_req.w.last;
  assign full  = (count == (PW+1)'(WR_OUTSTANDING));
  assign empty = (count == '0);
  assign head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // NOTE: grant storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= aw_idx;
  end

  assign r_ch  = CH_W'(mux_id_ch(32'(s_rid), BUS_WIDTH));
  assign b_ch  = CH_W'(mux_id_ch(32'(s_bid), BUS_WIDTH));
  assign r_hit = int'(r_ch) < N_MASTERS;
  assign b_hit = int'(b_ch) < N_MASTERS;

  assign s_arid = IDW'(mux_id_pack(32'(ar_idx), 32'(m_arid[ar_idx]), BUS_WIDTH));
  assign s_awid = IDW'(mux_id_pack(32'(aw_idx), 32'(m_awid[aw_idx]), BUS_WIDTH));
  assign s_wid  = IDW'(mux_id_pack(32'(head), 32'(m_wid[head]), BUS_WIDTH));

  always_comb begin
    s_axi_req          = '0;
    s_axi_req.ar       = m_axi_req[ar_idx].ar;
    s_axi_req.ar.valid = ar_valid;
    s_axi_req.aw       = m_axi_req[aw_idx].aw;
    s_axi_req.aw.valid = aw_valid;
    if (!empty) begin
      s_axi_req.w       = m_axi_req[head].w;
      s_axi_req.w.valid = m_axi_req[head].w.valid & ~rst;
    end
    // Beats tagged for a nonexistent channel are sunk so the bus never wedges.
    s_axi_req.rready = (r_hit ? m_axi_req[r_ch].rready : 1'b1) & ~rst;
    s_axi_req.bready = (b_hit ? m_axi_req[b_ch].bready : 1'b1) & ~rst;
  end

  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      m_axi_resp[i]         = '0;
      m_axi_resp[i].arready = s_axi_resp.arready & ar_gnt[i] & ~rst;
      m_axi_resp[i].awready = s_axi_resp.awready & aw_gnt[i] & ~full & ~rst;
      m_axi_resp[i].wready  = s_axi_resp.wready & ~empty & (head == CH_W'(i)) & ~rst;
      m_axi_resp[i].r       = s_axi_resp.r;
      m_axi_resp[i].r.valid = s_axi_resp.r.valid & r_hit & (r_ch == CH_W'(i)) & ~rst;
      m_axi_resp[i].b       = s_axi_resp.b;
      m_axi_resp[i].b.valid = s_axi_resp.b.valid & b_hit & (b_ch == CH_W'(i)) & ~rst;
      m_rid[i] = BUS_WIDTH'(mux_id_low(32'(s_rid), BUS_WIDTH));
      m_bid[i] = BUS_WIDTH'(mux_id_low(32'(s_bid), BUS_WIDTH));
    end
  end

endmodule

// File: tb/tb_axi_master_mux.sv
// Directed bench for axi_master_mux: AR/AW/W transfers are checked against
// queues filled as stimulus is driven; R/B routing and reset checked inline.
module tb_axi_master_mux;
  import axi_master_mux_pkg::*;

  localparam int N   = 3;
  localparam int BW  = 4;
  localparam int IDW = axi_id_tag_w(N, BW);

  logic            clk = 1'b0;
  logic            rst;
  axi_req_t        m_axi_req  [N];
  logic [BW-1:0]   m_arid [N], m_awid [N], m_wid [N];
  axi_resp_t       m_axi_resp [N];
  logic [BW-1:0]   m_rid [N], m_bid [N];
  axi_req_t        s_axi_req;
  logic [IDW-1:0]  s_arid, s_awid, s_wid;
  axi_resp_t       s_axi_resp;
  logic [IDW-1:0]  s_rid, s_bid;

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    logic           last;
  } exp_t;

  exp_t ar_q[$], aw_q[$], w_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  axi_master_mux #(.N_MASTERS(N), .BUS_WIDTH(BW), .WR_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .m_axi_req(m_axi_req), .m_arid(m_arid), .m_awid(m_awid), .m_wid(m_wid),
    .m_axi_resp(m_axi_resp), .m_rid(m_rid), .m_bid(m_bid),
    .s_axi_req(s_axi_req), .s_arid(s_arid), .s_awid(s_awid), .s_wid(s_wid),
    .s_axi_resp(s_axi_resp), .s_rid(s_rid), .s_bid(s_bid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_point();
    drive_point();
    rst = 1'b0;
  endtask

  task automatic expect_ar(input int budget);
    exp_t e;
    logic done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (s_axi_req.ar.valid && s_axi_resp.arready) begin
        e = ar_q.pop_front();
        check("ar_id", s_arid, e.id);
        check("ar_addr", s_axi_req.ar.addr, e.data);
        done = 1'b1;
      end
      drive_point();
    end
    check("ar_handshake_seen", done, 1'b1);
  endtask

  task automatic expect_aw(input int budget);
    exp_t e;
    logic done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (s_axi_req.aw.valid && s_axi_resp.awready) begin
        e = aw_q.pop_front();
        check("aw_id", s_awid, e.id);
        check("aw_addr", s_axi_req.aw.addr, e.data);
        done = 1'b1;
      end
      drive_point();
    end
    check("aw_handshake_seen", done, 1'b1);
  endtask

  task automatic expect_w(input int budget);
    exp_t e;
    logic done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (s_axi_req.w.valid && s_axi_resp.wready) begin
        e = w_q.pop_front();
        check("w_id", s_wid, e.id);
        check("w_data", s_axi_req.w.data, e.data);
        check("w_last", s_axi_req.w.last, e.last);
        done = 1'b1;
      end
      drive_point();
    end
    check("w_handshake_seen", done, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      m_axi_req[i] = '0;
      m_arid[i] = '0;
      m_awid[i] = '0;
      m_wid[i]  = '0;
    end
    s_axi_resp = '0;
    s_rid = '0;
    s_bid = '0;

    // Reset state
    drive_point();
    drive_point();
    @(negedge clk);
    check("rst_arvalid", s_axi_req.ar.valid, 1'b0);
    check("rst_awvalid", s_axi_req.aw.valid, 1'b0);
    check("rst_wvalid", s_axi_req.w.valid, 1'b0);
    check("rst_rready", s_axi_req.rready, 1'b0);
    check("rst_bready", s_axi_req.bready, 1'b0);
    drive_point();
    rst = 1'b0;
    @(negedge clk);
    check("idle_arvalid", s_axi_req.ar.valid, 1'b0);
    check("idle_wvalid", s_axi_req.w.valid, 1'b0);
    drive_point();

    // Stalled AR grant holds on master 1 although master 0 joins
    m_axi_req[1].ar.valid = 1'b1;
    m_axi_req[1].ar.addr  = 32'h1111_0000;
    m_arid[1] = 4'h4;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        m_axi_req[0].ar.valid = 1'b1;
        m_axi_req[0].ar.addr  = 32'h0000_00a0;
        m_arid[0] = 4'h2;
      end
      @(negedge clk);
      check("lock_arvalid", s_axi_req.ar.valid, 1'b1);
      check("lock_arid", s_arid, 6'h14);
      check("lock_araddr", s_axi_req.ar.addr, 32'h1111_0000);
      check("lock_m0_arready", m_axi_resp[0].arready, 1'b0);
      drive_point();
    end
    s_axi_resp.arready = 1'b1;
    ar_q.push_back('{32'h1111_0000, 6'h14, 1'b0});
    ar_q.push_back('{32'h0000_00a0, 6'h02, 1'b0});
    expect_ar(1);
    m_axi_req[1].ar.valid = 1'b0;
    expect_ar(1);
    m_axi_req[0].ar.valid = 1'b0;

    // Three simultaneous AR requesters rotate 0,1,2,0
    do_reset();
    m_arid[0] = 4'h3;  m_axi_req[0].ar.addr = 32'h100;
    m_arid[1] = 4'h7;  m_axi_req[1].ar.addr = 32'h200;
    m_arid[2] = 4'h9;  m_axi_req[2].ar.addr = 32'h300;
    for (int i = 0; i < N; i++) m_axi_req[i].ar.valid = 1'b1;
    ar_q.push_back('{32'h100, 6'h03, 1'b0});
    ar_q.push_back('{32'h200, 6'h17, 1'b0});
    ar_q.push_back('{32'h300, 6'h29, 1'b0});
    ar_q.push_back('{32'h100, 6'h03, 1'b0});
    for (int k = 0; k < 4; k++) expect_ar(1);
    for (int i = 0; i < N; i++) m_axi_req[i].ar.valid = 1'b0;

    // W follows AW order: master 2 (4 beats) before master 0
    s_axi_resp.awready = 1'b1;
    s_axi_resp.wready  = 1'b1;
    m_axi_req[2].aw = '{addr: 32'h2000, len: 8'd3, size: 3'd2, burst: 2'd1, valid: 1'b1};
    m_awid[2] = 4'h2;
    aw_q.push_back('{32'h2000, 6'h22, 1'b0});
    expect_aw(2);
    m_axi_req[2].aw.valid = 1'b0;
    m_axi_req[0].aw = '{addr: 32'h0400, len: 8'd0, size: 3'd2, burst: 2'd1, valid: 1'b1};
    m_awid[0] = 4'h1;
    aw_q.push_back('{32'h0400, 6'h01, 1'b0});
    expect_aw(2);
    m_axi_req[0].aw.valid = 1'b0;
    m_axi_req[0].w = '{data: 32'hd0d0_0000, strb: 4'hf, last: 1'b1, valid: 1'b1};
    m_wid[0] = 4'h1;
    m_wid[2] = 4'h2;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("wblock_wvalid", s_axi_req.w.valid, 1'b0);
      check("wblock_m0_wready", m_axi_resp[0].wready, 1'b0);
      drive_point();
    end
    for (int b = 0; b < 4; b++) begin
      m_axi_req[2].w = '{data: 32'h2000_0000 + b, strb: 4'hf, last: (b == 3), valid: 1'b1};
      w_q.push_back('{32'h2000_0000 + b, 6'h22, (b == 3)});
      expect_w(1);
    end
    m_axi_req[2].w.valid = 1'b0;
    w_q.push_back('{32'hd0d0_0000, 6'h01, 1'b1});
    expect_w(2);
    m_axi_req[0].w.valid = 1'b0;

    // AW-grant FIFO full blocks a fifth AW until one wlast pops
    m_axi_req[1].aw = '{addr: 32'h1000, len: 8'd0, size: 3'd2, burst: 2'd1, valid: 1'b1};
    for (int k = 0; k < 4; k++) begin
      m_awid[1] = 4'(k);
      aw_q.push_back('{32'h1000, 6'h10 | 6'(k), 1'b0});
      expect_aw(1);
    end
    m_axi_req[1].aw.valid = 1'b0;
    m_axi_req[0].aw = '{addr: 32'h0c00, len: 8'd0, size: 3'd2, burst: 2'd1, valid: 1'b1};
    m_awid[0] = 4'hc;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("full_awvalid", s_axi_req.aw.valid, 1'b0);
      check("full_m0_awready", m_axi_resp[0].awready, 1'b0);
      drive_point();
    end
    aw_q.push_back('{32'h0c00, 6'h0c, 1'b0});
    m_axi_req[1].w = '{data: 32'h1111_aaaa, strb: 4'hf, last: 1'b1, valid: 1'b1};
    m_wid[1] = 4'h8;
    w_q.push_back('{32'h1111_aaaa, 6'h18, 1'b1});
    expect_w(1);
    m_axi_req[1].w.valid = 1'b0;
    expect_aw(1);
    m_axi_req[0].aw.valid = 1'b0;

    // R/B routing by channel tag
    s_axi_resp.r = '{data: 32'hdead_beef, resp: 2'd0, last: 1'b1, valid: 1'b1};
    s_rid = 6'h15;
    m_axi_req[0].rready = 1'b1;
    m_axi_req[1].rready = 1'b0;
    m_axi_req[2].rready = 1'b1;
    @(negedge clk);
    check("r_valid_vec", {m_axi_resp[2].r.valid, m_axi_resp[1].r.valid, m_axi_resp[0].r.valid}, 3'b010);
    check("r_id_m1", m_rid[1], 4'h5);
    check("r_data_m1", m_axi_resp[1].r.data, 32'hdead_beef);
    check("r_stall_rready", s_axi_req.rready, 1'b0);
    drive_point();
    m_axi_req[1].rready = 1'b1;
    @(negedge clk);
    check("r_go_rready", s_axi_req.rready, 1'b1);
    drive_point();
    for (int i = 0; i < N; i++) m_axi_req[i].rready = 1'b0;
    s_rid = 6'h3a;
    @(negedge clk);
    check("r_sink_valid_vec", {m_axi_resp[2].r.valid, m_axi_resp[1].r.valid, m_axi_resp[0].r.valid}, 3'b000);
    check("r_sink_rready", s_axi_req.rready, 1'b1);
    drive_point();
    s_axi_resp.r.valid = 1'b0;
    s_axi_resp.b = '{resp: 2'd0, valid: 1'b1};
    s_bid = 6'h2a;
    @(negedge clk);
    check("b_valid_vec", {m_axi_resp[2].b.valid, m_axi_resp[1].b.valid, m_axi_resp[0].b.valid}, 3'b100);
    check("b_id_m2", m_bid[2], 4'ha);
    check("b_stall_bready", s_axi_req.bready, 1'b0);
    drive_point();
    s_axi_resp.b.valid = 1'b0;
    s_rid = '0;
    s_bid = '0;

    // Reset in the middle of a 4-beat write
    do_reset();
    s_axi_resp.arready = 1'b1;
    m_axi_req[0].ar.valid = 1'b1;
    m_axi_req[0].ar.addr  = 32'h600;
    m_arid[0] = 4'h6;
    ar_q.push_back('{32'h600, 6'h06, 1'b0});
    expect_ar(1);
    m_axi_req[0].ar.valid = 1'b0;
    m_axi_req[0].aw = '{addr: 32'h6000, len: 8'd3, size: 3'd2, burst: 2'd1, valid: 1'b1};
    m_awid[0] = 4'h6;
    aw_q.push_back('{32'h6000, 6'h06, 1'b0});
    expect_aw(1);
    m_axi_req[0].aw.valid = 1'b0;
    m_wid[0] = 4'h6;
    for (int b = 0; b < 2; b++) begin
      m_axi_req[0].w = '{data: 32'h6000_0000 + b, strb: 4'hf, last: 1'b0, valid: 1'b1};
      w_q.push_back('{32'h6000_0000 + b, 6'h06, 1'b0});
      expect_w(1);
    end
    m_axi_req[0].w.data = 32'h6000_0002;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wvalid", s_axi_req.w.valid, 1'b0);
    check("mid_rst_m0_wready", m_axi_resp[0].wready, 1'b0);
    drive_point();
    rst = 1'b0;
    s_axi_resp.arready = 1'b0;
    s_axi_resp.awready = 1'b0;
    m_axi_req[0].ar.valid = 1'b1;
    m_axi_req[1].ar.valid = 1'b1;
    m_arid[1] = 4'h7;
    @(negedge clk);
    check("post_rst_wvalid", s_axi_req.w.valid, 1'b0);
    check("post_rst_awvalid", s_axi_req.aw.valid, 1'b0);
    check("post_rst_arvalid", s_axi_req.ar.valid, 1'b1);
    check("post_rst_ar_ptr", s_arid, 6'h06);
    drive_point();
    m_axi_req[0].aw.valid = 1'b1;
    m_axi_req[1].aw.valid = 1'b1;
    m_awid[1] = 4'h7;
    @(negedge clk);
    check("post_rst_aw_ptr", s_awid, 6'h06);
    check("post_rst_wvalid2", s_axi_req.w.valid, 1'b0);
    drive_point();
    for (int i = 0; i < N; i++) m_axi_req[i] = '0;

    check("ar_q_drained", ar_q.size(), 0);
    check("aw_q_drained", aw_q.size(), 0);
    check("w_q_drained", w_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
